mxv_row_mac: RTL and testbench



---
 rtl/mxv_pkg.sv | 19 +
 rtl/mxv_row_mac_if.sv | 30 +++
 rtl/mxv_product_stage.sv | 32 +++
 rtl/mxv_row_mac.sv | 111 +++++++++++
 tb/tb_mxv_row_mac.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mxv_pkg.sv
// Shared widths, the result "empty" marker and the FSM state type for the MxV
// row multiply-accumulate stage.
package mxv_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int VEC_LEN    = 4;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(VEC_LEN);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    // No legal dot product reaches all-ones, so it doubles as "no result yet".
    localparam logic [ACC_WIDTH-1:0] ACC_EMPTY = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} mac_state_t;

    typedef logic [DATA_WIDTH-1:0] elem_t;
    typedef logic [PROD_WIDTH-1:0] prod_t;
    typedef logic [ACC_WIDTH-1:0]  acc_t;

endpackage

// File: rtl/mxv_row_mac_if.sv
// Row interface: start/element handshake in, dot product and status out.
// An element pair moves on a rising edge where in_valid && in_ready; in_ready is a
// function of FSM state only and never looks at in_valid.
interface mxv_row_mac_if
    import mxv_pkg::*;
#(
    parameter int DATA_WIDTH = mxv_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = mxv_pkg::ACC_WIDTH
);

    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] b_in;
    logic                  in_ready;
    logic [ACC_WIDTH-1:0]  result;
    logic                  result_valid;
    logic                  busy;

    modport master (
        output start, in_valid, a_in, b_in,
        input  in_ready, result, result_valid, busy
    );

    modport slave (
        input  start, in_valid, a_in, b_in,
        output in_ready, result, result_valid, busy
    );

endinterface

// File: rtl/mxv_product_stage.sv
// Registered unsigned multiplier: captures a*b on each accepted pair and flags
// prod_valid for exactly the cycle after the accept.
module mxv_product_stage
    import mxv_pkg::*;
#(
    parameter int DATA_WIDTH = mxv_pkg::DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sys_reset,
    input  logic                    accept,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] prod_reg,
    output logic                    prod_valid
);

    localparam int PW = 2 * DATA_WIDTH;

    always_ff @(posedge clk) begin
        if (reset || sys_reset) begin
            prod_reg   <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= accept;
            if (accept) begin
                prod_reg <= PW'(a) * PW'(b);
            end
        end
    end

endmodule

// File: rtl/mxv_row_mac.sv
// Row dot-product engine: accepts VEC_LEN element pairs, accumulates their
// products and strobes the finished sum one cycle after the last accept.
module mxv_row_mac
    import mxv_pkg::*;
#(
    parameter int DATA_WIDTH = mxv_pkg::DATA_WIDTH,
    parameter int VEC_LEN    = mxv_pkg::VEC_LEN,
    parameter int ACC_WIDTH  = mxv_pkg::ACC_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sys_reset,
    mxv_row_mac_if.slave bus,
    output mac_state_t state
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(VEC_LEN);

    mac_state_t             state_next;
    logic                   clear;
    logic                   accept;
    logic                   last_elem;
    logic                   in_ready_c;
    logic                   busy_c;
    logic [CNT_W-1:0]       elem_cnt;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   result_q;
    logic                   result_valid_q;
    logic [PW-1:0]          prod_reg;
    logic                   prod_valid;

    assign clear     = reset || sys_reset;
    assign last_elem = (elem_cnt == CNT_W'(VEC_LEN - 1));

    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = ACCUM;
            end
            ACCUM: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b1;
                accept     = bus.in_valid;
                if (accept && last_elem) state_next = DRAIN;
            end
            DRAIN: begin
                busy_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_next;
    end

    // The final product is still in prod_reg during DRAIN, so it is folded in there.
    always_ff @(posedge clk) begin
        if (clear) begin
            acc            <= '0;
            elem_cnt       <= '0;
            result_q       <= '1;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc      <= '0;
                        elem_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (accept)     elem_cnt <= elem_cnt + CNT_W'(1);
                    if (prod_valid) acc      <= acc + ACC_WIDTH'(prod_reg);
                end
                DRAIN: begin
                    result_q       <= acc + ACC_WIDTH'(prod_reg);
                    result_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    mxv_product_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_product (
        .clk        (clk),
        .reset      (reset),
        .sys_reset  (sys_reset),
        .accept     (accept),
        .a          (bus.a_in),
        .b          (bus.b_in),
        .prod_reg   (prod_reg),
        .prod_valid (prod_valid)
    );

    assign bus.in_ready     = in_ready_c;
    assign bus.busy         = busy_c;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_mxv_row_mac.sv
// Directed bench for mxv_row_mac: hand-computed dot products, gaps, soft clear,
// ignored starts and back-to-back rows.
module tb_mxv_row_mac;
    import mxv_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       sys_reset;
    mac_state_t state;

    int errors  = 0;
    int checks  = 0;
    int strobes = 0;
    logic prev_rv = 1'b0;

    mxv_row_mac_if #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

    mxv_row_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .VEC_LEN    (VEC_LEN),
        .ACC_WIDTH  (ACC_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sys_reset (sys_reset),
        .bus       (bus.slave),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.result_valid) begin
            strobes++;
            check("rv_one_cycle", 64'(prev_rv), 64'd0);
        end
        prev_rv = bus.result_valid;
    endtask

    task automatic start_row(input logic [15:0] a, input logic [15:0] b, input logic vld);
        bus.start    = 1'b1;
        bus.in_valid = vld;
        bus.a_in     = a;
        bus.b_in     = b;
        check("in_ready_idle", 64'(bus.in_ready), 64'd0);
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("state_after_start", 64'(state), 64'(ACCUM));
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input int gap);
        repeat (gap) begin
            bus.in_valid = 1'b0;
            tick();
            check("busy_in_gap", 64'(bus.busy), 64'd1);
        end
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        check("in_ready_accum", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_row(input string tag, input logic [63:0] exp);
        int s0;
        check({tag, "_drain_state"}, 64'(state), 64'(DRAIN));
        check({tag, "_drain_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_rv_early"}, 64'(bus.result_valid), 64'd0);
        s0 = strobes;
        tick();
        check({tag, "_rv"}, 64'(bus.result_valid), 64'd1);
        check({tag, "_result"}, 64'(bus.result), exp);
        check({tag, "_one_strobe"}, 64'(strobes - s0), 64'd1);
        tick();
        check({tag, "_rv_drop"}, 64'(bus.result_valid), 64'd0);
        check({tag, "_result_hold"}, 64'(bus.result), exp);
        check({tag, "_idle"}, 64'(state), 64'(IDLE));
        check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int s0;
        reset        = 1'b1;
        sys_reset    = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("reset_result", 64'(bus.result), 64'(ACC_EMPTY));
        check("reset_rv", 64'(bus.result_valid), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_state", 64'(state), 64'(IDLE));

        // 1*5 + 2*6 + 3*7 + 4*8 = 70
        start_row(16'd0, 16'd0, 1'b0);
        send_pair(16'd1, 16'd5, 0);
        send_pair(16'd2, 16'd6, 0);
        send_pair(16'd3, 16'd7, 0);
        send_pair(16'd4, 16'd8, 0);
        finish_row("basic", 64'h46);

        // 4 * 0xFFFE0001 = 0x3_FFF8_0004, with uneven input gaps
        start_row(16'd0, 16'd0, 1'b0);
        send_pair(16'hFFFF, 16'hFFFF, 0);
        send_pair(16'hFFFF, 16'hFFFF, 2);
        send_pair(16'hFFFF, 16'hFFFF, 1);
        send_pair(16'hFFFF, 16'hFFFF, 0);
        finish_row("max", 64'h3_FFF8_0004);

        // Soft clear mid-row discards the partial sum
        start_row(16'd0, 16'd0, 1'b0);
        send_pair(16'd9, 16'd9, 0);
        send_pair(16'd9, 16'd9, 0);
        s0 = strobes;
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        check("clr_state", 64'(state), 64'(IDLE));
        check("clr_result", 64'(bus.result), 64'(ACC_EMPTY));
        check("clr_rv", 64'(bus.result_valid), 64'd0);
        check("clr_busy", 64'(bus.busy), 64'd0);
        repeat (3) tick();
        check("clr_no_strobe", 64'(strobes - s0), 64'd0);
        check("clr_result_hold", 64'(bus.result), 64'(ACC_EMPTY));
        start_row(16'd0, 16'd0, 1'b0);
        repeat (4) send_pair(16'd1, 16'd1, 0);
        finish_row("after_clr", 64'd4);

        // start during ACCUM and DRAIN ignored; start in the strobe cycle launches row 2
        start_row(16'd0, 16'd0, 1'b0);
        send_pair(16'd1, 16'd2, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_accum_state", 64'(state), 64'(ACCUM));
        check("start_accum_busy", 64'(bus.busy), 64'd1);
        send_pair(16'd3, 16'd4, 0);
        send_pair(16'd5, 16'd6, 0);
        send_pair(16'd7, 16'd8, 0);
        check("b2b_drain", 64'(state), 64'(DRAIN));
        bus.start = 1'b1;
        tick();
        check("b2b_rv1", 64'(bus.result_valid), 64'd1);
        check("b2b_result1", 64'(bus.result), 64'd100);
        check("b2b_idle", 64'(state), 64'(IDLE));
        bus.in_valid = 1'b1;
        bus.a_in     = 16'd50;
        bus.b_in     = 16'd50;
        check("b2b_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("b2b_accum", 64'(state), 64'(ACCUM));
        check("b2b_rv_drop", 64'(bus.result_valid), 64'd0);
        check("b2b_hold1", 64'(bus.result), 64'd100);
        repeat (4) send_pair(16'd2, 16'd3, 0);
        finish_row("row2", 64'd24);

        // Pair presented with start in IDLE must not be counted
        start_row(16'd100, 16'd100, 1'b1);
        repeat (4) send_pair(16'd1, 16'd1, 0);
        finish_row("start_pair", 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
